// File: rtl/da_ctrl_pkg.sv
// rtl/da_ctrl_pkg.sv - shared constants and types for the NCO update controller
//
// Purpose: default register addresses, command bit positions and the
// update-sequence state enumeration used by da_nco_update_ctrl and
// da_shadow_regs.
package da_ctrl_pkg;

  localparam logic [15:0] DEF_ADDR_FAH = 16'h0002;
  localparam logic [15:0] DEF_ADDR_FAL = 16'h0003;
  localparam logic [15:0] DEF_ADDR_FBH = 16'h0004;
  localparam logic [15:0] DEF_ADDR_FBL = 16'h0005;
  localparam logic [15:0] DEF_ADDR_PA  = 16'h0006;
  localparam logic [15:0] DEF_ADDR_PB  = 16'h0007;
  localparam logic [15:0] DEF_ADDR_CMD = 16'h000C;

  localparam int CMD_COMMIT_BIT  = 0;
  localparam int CMD_RUN_BIT     = 1;
  localparam int CMD_CLR_ERR_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STOP   = 3'd1,
    ST_CLR    = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_START  = 3'd5
  } state_t;

endpackage

// File: rtl/da_shadow_regs.sv
// rtl/da_shadow_regs.sv - bus write decode and shadow register bank
//
// Purpose: captures bus writes into the six shadow registers and flags
// command-register writes for the controller FSM.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cs_n, i_wr_en       chip select (active-low), write enable
//   i_addr, i_data        bus address / write data
//   o_fah..o_pb           shadow register contents
//   o_cmd_wr              one-cycle strobe: a write to the command address
//   o_cmd_bits            command bits [2:0] of that write
module da_shadow_regs
  import da_ctrl_pkg::*;
#(
  parameter logic [15:0] ADDR_FAH = DEF_ADDR_FAH,
  parameter logic [15:0] ADDR_FAL = DEF_ADDR_FAL,
  parameter logic [15:0] ADDR_FBH = DEF_ADDR_FBH,
  parameter logic [15:0] ADDR_FBL = DEF_ADDR_FBL,
  parameter logic [15:0] ADDR_PA  = DEF_ADDR_PA,
  parameter logic [15:0] ADDR_PB  = DEF_ADDR_PB,
  parameter logic [15:0] ADDR_CMD = DEF_ADDR_CMD
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs_n,
  input  logic        i_wr_en,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data,
  output logic [15:0] o_fah,
  output logic [15:0] o_fal,
  output logic [15:0] o_fbh,
  output logic [15:0] o_fbl,
  output logic [15:0] o_pa,
  output logic [15:0] o_pb,
  output logic        o_cmd_wr,
  output logic [2:0]  o_cmd_bits
);

  logic        w_wr;
  logic [15:0] r_fah, r_fal, r_fbh, r_fbl, r_pa, r_pb;

  assign w_wr = ~i_cs_n & i_wr_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fah <= '0;
      r_fal <= '0;
      r_fbh <= '0;
      r_fbl <= '0;
      r_pa  <= '0;
      r_pb  <= '0;
    end else if (w_wr) begin
      // Unmapped addresses (including CMD) fall through untouched.
      if (i_addr == ADDR_FAH) r_fah <= i_data;
      if (i_addr == ADDR_FAL) r_fal <= i_data;
      if (i_addr == ADDR_FBH) r_fbh <= i_data;
      if (i_addr == ADDR_FBL) r_fbl <= i_data;
      if (i_addr == ADDR_PA)  r_pa  <= i_data;
      if (i_addr == ADDR_PB)  r_pb  <= i_data;
    end
  end

  assign o_fah      = r_fah;
  assign o_fal      = r_fal;
  assign o_fbh      = r_fbh;
  assign o_fbl      = r_fbl;
  assign o_pa       = r_pa;
  assign o_pb       = r_pb;
  assign o_cmd_wr   = w_wr && (i_addr == ADDR_CMD);
  assign o_cmd_bits = i_data[2:0];

endmodule

// File: rtl/da_nco_update_ctrl.sv
// rtl/da_nco_update_ctrl.sv - glitch-free NCO frequency/phase update sequencer
//
// Purpose: on a COMMIT command, stops the NCO, clears its accumulator, copies
// the shadow frequency/phase words to the active outputs, waits SETTLE_CYC
// cycles and restarts the NCO.
// Ports:
//   CLK_BASE, RST             clock, synchronous active-high reset
//   CS, WR_EN, ADDR, DATA     register write bus (CS active-low)
//   FREQAH_W..FREQBL_W        active frequency words
//   PHASEA_OUT, PHASEB_OUT    active phase words
//   NCO_EN, ACC_CLR           NCO accumulate enable / accumulator clear
//   BUSY, DONE, ERR           sequence in progress / completion pulse / sticky error
module da_nco_update_ctrl
  import da_ctrl_pkg::*;
#(
  parameter logic [15:0] ADDR_FAH   = DEF_ADDR_FAH,
  parameter logic [15:0] ADDR_FAL   = DEF_ADDR_FAL,
  parameter logic [15:0] ADDR_FBH   = DEF_ADDR_FBH,
  parameter logic [15:0] ADDR_FBL   = DEF_ADDR_FBL,
  parameter logic [15:0] ADDR_PA    = DEF_ADDR_PA,
  parameter logic [15:0] ADDR_PB    = DEF_ADDR_PB,
  parameter logic [15:0] ADDR_CMD   = DEF_ADDR_CMD,
  parameter int          SETTLE_CYC = 16
) (
  input  logic        CLK_BASE,
  input  logic        RST,
  input  logic        CS,
  input  logic        WR_EN,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA,
  output logic [15:0] FREQAH_W,
  output logic [15:0] FREQAL_W,
  output logic [15:0] FREQBH_W,
  output logic [15:0] FREQBL_W,
  output logic [15:0] PHASEA_OUT,
  output logic [15:0] PHASEB_OUT,
  output logic        NCO_EN,
  output logic        ACC_CLR,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  // Counter is preloaded with S-1 in LOAD so SETTLE lasts exactly S cycles.
  // Unused when SETTLE_CYC is 0 because LOAD then skips SETTLE.
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC - 1);

  state_t      r_state, w_next;
  logic        r_run_en, r_err;
  logic [7:0]  r_settle_cnt;
  logic [15:0] r_fah, r_fal, r_fbh, r_fbl, r_pa, r_pb;

  logic [15:0] w_sh_fah, w_sh_fal, w_sh_fbh, w_sh_fbl, w_sh_pa, w_sh_pb;
  logic        w_cmd_wr;
  logic [2:0]  w_cmd_bits;
  logic        w_busy, w_nco_en, w_acc_clr, w_done;
  logic        w_commit;

  da_shadow_regs #(
    .ADDR_FAH (ADDR_FAH),
    .ADDR_FAL (ADDR_FAL),
    .ADDR_FBH (ADDR_FBH),
    .ADDR_FBL (ADDR_FBL),
    .ADDR_PA  (ADDR_PA),
    .ADDR_PB  (ADDR_PB),
    .ADDR_CMD (ADDR_CMD)
  ) u_shadow (
    .i_clk      (CLK_BASE),
    .i_rst      (RST),
    .i_cs_n     (CS),
    .i_wr_en    (WR_EN),
    .i_addr     (ADDR),
    .i_data     (DATA),
    .o_fah      (w_sh_fah),
    .o_fal      (w_sh_fal),
    .o_fbh      (w_sh_fbh),
    .o_fbl      (w_sh_fbl),
    .o_pa       (w_sh_pa),
    .o_pb       (w_sh_pb),
    .o_cmd_wr   (w_cmd_wr),
    .o_cmd_bits (w_cmd_bits)
  );

  assign w_commit = w_cmd_wr && w_cmd_bits[CMD_COMMIT_BIT];

  // State register
  always_ff @(posedge CLK_BASE) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; commits are only honoured from IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_commit) w_next = ST_STOP;
      ST_STOP:   w_next = ST_CLR;
      ST_CLR:    w_next = ST_LOAD;
      ST_LOAD:   w_next = (SETTLE_CYC == 0) ? ST_START : ST_SETTLE;
      ST_SETTLE: if (r_settle_cnt == 8'd0) w_next = ST_START;
      ST_START:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    w_busy    = 1'b1;
    w_nco_en  = 1'b0;
    w_acc_clr = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy   = 1'b0;
        w_nco_en = r_run_en;
      end
      ST_CLR:   w_acc_clr = 1'b1;
      ST_START: begin
        w_nco_en = 1'b1;
        w_done   = 1'b1;
      end
      default: ;
    endcase
  end

  // Active registers, settle counter, run enable and sticky error
  always_ff @(posedge CLK_BASE) begin
    if (RST) begin
      r_fah        <= '0;
      r_fal        <= '0;
      r_fbh        <= '0;
      r_fbl        <= '0;
      r_pa         <= '0;
      r_pb         <= '0;
      r_settle_cnt <= '0;
      r_run_en     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // LOAD samples the shadow registers as they stood before this edge, so
      // a bus write landing on the same edge stays in the shadow bank.
      if (r_state == ST_LOAD) begin
        r_fah        <= w_sh_fah;
        r_fal        <= w_sh_fal;
        r_fbh        <= w_sh_fbh;
        r_fbl        <= w_sh_fbl;
        r_pa         <= w_sh_pa;
        r_pb         <= w_sh_pb;
        r_settle_cnt <= SETTLE_INIT;
      end else if (r_state == ST_SETTLE && r_settle_cnt != 8'd0) begin
        r_settle_cnt <= r_settle_cnt - 8'd1;
      end

      if (r_state == ST_START)
        r_run_en <= 1'b1;
      else if (r_state == ST_IDLE && w_cmd_wr && !w_cmd_bits[CMD_COMMIT_BIT])
        r_run_en <= w_cmd_bits[CMD_RUN_BIT];

      // Any command during a sequence is an error; setting beats clearing.
      if (w_cmd_wr && w_busy)
        r_err <= 1'b1;
      else if (w_cmd_wr && w_cmd_bits[CMD_CLR_ERR_BIT])
        r_err <= 1'b0;
    end
  end

  assign FREQAH_W   = r_fah;
  assign FREQAL_W   = r_fal;
  assign FREQBH_W   = r_fbh;
  assign FREQBL_W   = r_fbl;
  assign PHASEA_OUT = r_pa;
  assign PHASEB_OUT = r_pb;
  assign NCO_EN     = w_nco_en;
  assign ACC_CLR    = w_acc_clr;
  assign BUSY       = w_busy;
  assign DONE       = w_done;
  assign ERR        = r_err;

endmodule

// File: tb/tb_da_nco_update_ctrl.sv
// tb/tb_da_nco_update_ctrl.sv - directed self-checking bench for da_nco_update_ctrl
module tb_da_nco_update_ctrl;
  import da_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, cs, wr_en;
  logic [15:0] addr, data;

  logic [15:0] fah, fal, fbh, fbl, pa, pb;
  logic        nco_en, acc_clr, busy, done, err;

  logic [15:0] fah_z, fal_z, fbh_z, fbl_z, pa_z, pb_z;
  logic        nco_en_z, acc_clr_z, busy_z, done_z, err_z;

  int total = 0;
  int bad   = 0;
  int done_cnt;

  always #5 clk = ~clk;

  da_nco_update_ctrl #(.SETTLE_CYC(16)) u_dut (
    .CLK_BASE(clk), .RST(rst), .CS(cs), .WR_EN(wr_en), .ADDR(addr), .DATA(data),
    .FREQAH_W(fah), .FREQAL_W(fal), .FREQBH_W(fbh), .FREQBL_W(fbl),
    .PHASEA_OUT(pa), .PHASEB_OUT(pb),
    .NCO_EN(nco_en), .ACC_CLR(acc_clr), .BUSY(busy), .DONE(done), .ERR(err)
  );

  da_nco_update_ctrl #(.SETTLE_CYC(0)) u_dut_s0 (
    .CLK_BASE(clk), .RST(rst), .CS(cs), .WR_EN(wr_en), .ADDR(addr), .DATA(data),
    .FREQAH_W(fah_z), .FREQAL_W(fal_z), .FREQBH_W(fbh_z), .FREQBL_W(fbl_z),
    .PHASEA_OUT(pa_z), .PHASEB_OUT(pb_z),
    .NCO_EN(nco_en_z), .ACC_CLR(acc_clr_z), .BUSY(busy_z), .DONE(done_z), .ERR(err_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cs = 1'b0; wr_en = 1'b1; addr = a; data = d;
    tick();
    cs = 1'b1; wr_en = 1'b0;
  endtask

  initial begin
    cs = 1'b1; wr_en = 1'b0; addr = '0; data = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk ("rst_fah",     fah, 16'h0000);
    chk ("rst_pa",      pa,  16'h0000);
    chk1("rst_busy",    busy,    1'b0);
    chk1("rst_nco_en",  nco_en,  1'b0);
    chk1("rst_acc_clr", acc_clr, 1'b0);
    chk1("rst_done",    done,    1'b0);
    chk1("rst_err",     err,     1'b0);

    // Shadow writes must not touch active outputs; unmapped write ignored.
    wr(DEF_ADDR_FAH, 16'h0147);
    wr(DEF_ADDR_FAL, 16'hAE14);
    wr(16'h0009, 16'hFFFF);
    chk ("shadow_no_active", fah, 16'h0000);
    chk1("unmapped_no_err",  err, 1'b0);

    // Commit at N (S=16)
    wr(DEF_ADDR_CMD, 16'h0001);                 // now N+1 (STOP)
    chk1("n1_busy",    busy,    1'b1);
    chk1("n1_nco_en",  nco_en,  1'b0);
    chk1("n1_acc_clr", acc_clr, 1'b0);
    chk ("n1_fah",     fah,     16'h0000);
    tick();                                     // N+2 (CLR)
    chk1("n2_acc_clr", acc_clr, 1'b1);
    chk ("n2_fah",     fah,     16'h0000);
    tick();                                     // N+3 (LOAD)
    chk1("n3_acc_clr", acc_clr, 1'b0);
    chk ("n3_fah",     fah,     16'h0000);
    wr(DEF_ADDR_PA, 16'h0200);                  // write during LOAD; now N+4
    chk ("n4_fah",     fah,     16'h0147);
    chk ("n4_fal",     fal,     16'hAE14);
    chk ("n4_pa_old",  pa,      16'h0000);
    chk1("n4_nco_en",  nco_en,  1'b0);
    tick();                                     // N+5
    wr(DEF_ADDR_CMD, 16'h0001);                 // commit while busy; now N+6
    chk1("n6_err",     err,     1'b1);
    chk1("n6_busy",    busy,    1'b1);
    chk1("n6_acc_clr", acc_clr, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      done_cnt += int'(done);
      tick();
    end                                          // N+20 (START)
    chk1("n20_done",   done,   1'b1);
    chk1("n20_nco_en", nco_en, 1'b1);
    chk1("n20_busy",   busy,   1'b1);
    done_cnt += int'(done);
    tick();                                     // N+21 (IDLE)
    chk1("n21_busy",   busy,   1'b0);
    chk1("n21_done",   done,   1'b0);
    chk1("n21_nco_en", nco_en, 1'b1);
    for (int i = 0; i < 4; i++) begin
      done_cnt += int'(done);
      tick();
    end
    chk("one_done_pulse", 16'(done_cnt), 16'd1);

    // Clear error in IDLE (also drops run_en)
    wr(DEF_ADDR_CMD, 16'h0004);
    chk1("clr_err",        err,    1'b0);
    chk1("clr_nco_en_off", nco_en, 1'b0);
    wr(DEF_ADDR_CMD, 16'h0002);
    chk1("run_nco_en",     nco_en, 1'b1);
    chk1("run_busy",       busy,   1'b0);

    // Commit at M; set+clear error in the same cycle at M+1
    wr(DEF_ADDR_CMD, 16'h0001);                 // M+1
    wr(DEF_ADDR_CMD, 16'h0005);                 // M+2
    chk1("m2_err_set_wins", err,     1'b1);
    chk1("m2_acc_clr",      acc_clr, 1'b1);
    tick(); tick();                             // M+4
    chk ("m4_pa_new",       pa,      16'h0200);
    for (int i = 0; i < 17; i++) tick();        // M+21
    chk1("m21_busy",        busy,    1'b0);
    wr(DEF_ADDR_CMD, 16'h0004);
    chk1("later_clr_err",   err,     1'b0);

    // S=0 instance: commit at K -> START/DONE at K+4
    wr(DEF_ADDR_CMD, 16'h0001);                 // K+1
    tick(); tick();                             // K+3
    chk1("s0_k3_done",   done_z,   1'b0);
    chk1("s0_k3_busy",   busy_z,   1'b1);
    tick();                                     // K+4
    chk1("s0_k4_done",   done_z,   1'b1);
    chk1("s0_k4_nco_en", nco_en_z, 1'b1);
    chk ("s0_k4_fah",    fah_z,    16'h0147);
    tick();                                     // K+5
    chk1("s0_k5_busy",   busy_z,   1'b0);
    chk1("s0_k5_done",   done_z,   1'b0);
    for (int i = 0; i < 16; i++) tick();        // K+21
    chk1("k21_busy",     busy,     1'b0);

    // Reset during SETTLE at R+6
    wr(DEF_ADDR_CMD, 16'h0001);                 // R+1
    for (int i = 0; i < 5; i++) tick();         // R+6
    chk1("r6_busy", busy, 1'b1);
    rst = 1'b1;
    tick();                                     // R+7
    rst = 1'b0;
    chk1("r7_busy",    busy,    1'b0);
    chk1("r7_nco_en",  nco_en,  1'b0);
    chk1("r7_done",    done,    1'b0);
    chk1("r7_acc_clr", acc_clr, 1'b0);
    chk1("r7_err",     err,     1'b0);
    chk ("r7_fah",     fah,     16'h0000);
    chk ("r7_pa",      pa,      16'h0000);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      done_cnt += int'(done) + int'(busy) + int'(nco_en);
    end
    chk("post_rst_quiet", 16'(done_cnt), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
